uart_tx_fifo: RTL

//  Upstream feeder for uart_tx: buffers bytes from the producer in a circular FIFO.

---
 rtl/uart_tx_fifo.sv | 101 ++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - circular byte FIFO that feeds uart_tx one frame at a time
module uart_tx_fifo #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   w_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              tx_done_tick,
    output logic              tx_start,
    output logic [DBIT-1:0]   din,
    output logic              busy
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

    state_t                  state;
    logic [DBIT-1:0]         mem [2**ADDR_W];
    logic [ADDR_W-1:0]       wr_ptr;
    logic [ADDR_W-1:0]       rd_ptr;
    logic                    push;
    logic                    pop;

    // full/empty come from the registered count, so a pop cannot make room
    // for a write in the same cycle
    assign full  = (count == DEPTH);
    assign empty = (count == '0);
    assign push  = wr_en && !full;
    assign pop   = (state == IDLE) && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (ADDR_W+1)'(1);
            end else if (pop && !push) begin
                count <= count - (ADDR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            tx_start <= 1'b0;
            din      <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_start <= 1'b0;
                    if (pop) begin
                        din      <= mem[rd_ptr];
                        rd_ptr   <= rd_ptr + ADDR_W'(1);
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    tx_start <= 1'b0;
                    state    <= BUSY;
                end
                BUSY: begin
                    tx_start <= 1'b0;
                    if (tx_done_tick) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
